hazard_stall_controller: RTL and testbench

Pipeline sequencing controller that works alongside the forwarding logic. It resolves the hazards forwarding cannot cover: load-use stalls, taken-branch flushes in EX, and multi-cycle data-memory waits in MEM. It drives the PC, IF/ID, ID/EX and EX/MEM write/flush controls. It also keeps a memory-timeout watchdog and performance counters.

---
 rtl/hazard_stall_controller.sv | 76 +++++++
 tb/tb_hazard_stall_controller.sv | 129 ++++++++++++
 2 files changed

// File: rtl/hazard_stall_controller.sv
// hazard_stall_controller: load-use stalls, branch flushes and memory-wait freezes for the pipeline, plus a memory watchdog and perf counters
module hazard_stall_controller #(
    parameter int CNT_W       = 32,
    parameter int MEM_TIMEOUT = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [4:0]       rs1_if_id,
    input  logic [4:0]       rs2_if_id,
    input  logic             uses_rs2_if_id,
    input  logic [4:0]       rd_id_ex,
    input  logic             mem_read_id_ex,
    input  logic             branch_taken_ex,
    input  logic             dmem_req_ex_mem,
    input  logic             dmem_ready,
    output logic             pc_write,
    output logic             if_id_write,
    output logic             if_id_flush,
    output logic             id_ex_bubble,
    output logic             ex_mem_hold,
    output logic             mem_timeout,
    output logic [CNT_W-1:0] stall_cycles,
    output logic [CNT_W-1:0] flush_count,
    output logic [1:0]       state
);
    localparam int WW = $clog2(MEM_TIMEOUT) + 1;
    typedef enum logic [1:0] {RUN = 2'd0, LOAD_STALL = 2'd1, MEM_WAIT = 2'd2} state_t;
    state_t st, st_nxt;
    logic [WW-1:0] wait_cnt;
    logic freeze, load_use, flush;
    assign freeze = dmem_req_ex_mem & ~dmem_ready;
    assign load_use = mem_read_id_ex & (rd_id_ex != 5'd0) &
                      ((rd_id_ex == rs1_if_id) | (uses_rs2_if_id & (rd_id_ex == rs2_if_id)));
    assign state = st;
    always_comb begin
        pc_write     = 1'b1;
        if_id_write  = 1'b1;
        if_id_flush  = 1'b0;
        id_ex_bubble = 1'b0;
        ex_mem_hold  = 1'b0;
        flush        = 1'b0;
        st_nxt       = RUN;
        if (!reset && st != 2'd3) begin
            if (freeze) begin
                pc_write    = 1'b0;
                if_id_write = 1'b0;
                ex_mem_hold = 1'b1;
                st_nxt      = MEM_WAIT;
            end else if (branch_taken_ex) begin
                if_id_flush  = 1'b1;
                id_ex_bubble = 1'b1;
                flush        = 1'b1;
            end else if (load_use && st != LOAD_STALL) begin
                pc_write     = 1'b0;
                if_id_write  = 1'b0;
                id_ex_bubble = 1'b1;
                st_nxt       = LOAD_STALL;
            end
        end
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            st           <= RUN;
            wait_cnt     <= '0;
            mem_timeout  <= 1'b0;
            stall_cycles <= '0;
            flush_count  <= '0;
        end else begin
            st           <= st_nxt;
            wait_cnt     <= !freeze ? '0 : (&wait_cnt ? wait_cnt : wait_cnt + 1'b1);
            mem_timeout  <= mem_timeout | (freeze && wait_cnt == WW'(MEM_TIMEOUT - 1));
            stall_cycles <= (!pc_write && !(&stall_cycles)) ? stall_cycles + 1'b1 : stall_cycles;
            flush_count  <= (flush && !(&flush_count)) ? flush_count + 1'b1 : flush_count;
        end
    end
endmodule

// File: tb/tb_hazard_stall_controller.sv
// tb_hazard_stall_controller: directed scoreboard bench for hazard_stall_controller (CNT_W=3, MEM_TIMEOUT=4)
module tb_hazard_stall_controller;
    logic clk = 1'b0;
    logic reset;
    logic [4:0] rs1, rs2, rd;
    logic u2, mr, br, req, rdy;
    logic pc_write, if_id_write, if_id_flush, id_ex_bubble, ex_mem_hold, mem_timeout;
    logic [2:0] stall_cycles, flush_count;
    logic [1:0] state;
    int errors = 0;
    int checks = 0;
    typedef struct packed {
        logic pc, ifw, fl, bub, hold, to;
        logic [1:0] st;
        logic [2:0] sc, fc;
    } exp_t;
    exp_t sb[$];

    hazard_stall_controller #(.CNT_W(3), .MEM_TIMEOUT(4)) dut (
        .clk(clk), .reset(reset),
        .rs1_if_id(rs1), .rs2_if_id(rs2), .uses_rs2_if_id(u2),
        .rd_id_ex(rd), .mem_read_id_ex(mr), .branch_taken_ex(br),
        .dmem_req_ex_mem(req), .dmem_ready(rdy),
        .pc_write(pc_write), .if_id_write(if_id_write), .if_id_flush(if_id_flush),
        .id_ex_bubble(id_ex_bubble), .ex_mem_hold(ex_mem_hold), .mem_timeout(mem_timeout),
        .stall_cycles(stall_cycles), .flush_count(flush_count), .state(state)
    );

    always #5 clk = ~clk;

    task automatic drive(input logic [4:0] a, b, input logic c, input logic [4:0] d,
                         input logic e, f, g, h);
        rs1 = a; rs2 = b; u2 = c; rd = d; mr = e; br = f; req = g; rdy = h;
    endtask

    task automatic cmp(input string tag, input logic [7:0] obs, input logic [7:0] want);
        checks++;
        assert (obs === want) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, want);
        end
    endtask

    task automatic step(input string tag, input logic pc, ifw, fl, bub, hold, to,
                        input logic [1:0] st, input logic [2:0] sc, fc);
        exp_t e;
        sb.push_back({pc, ifw, fl, bub, hold, to, st, sc, fc});
        @(negedge clk);
        e = sb.pop_front();
        cmp({tag, ".pc_write"}, {7'd0, pc_write}, {7'd0, e.pc});
        cmp({tag, ".if_id_write"}, {7'd0, if_id_write}, {7'd0, e.ifw});
        cmp({tag, ".if_id_flush"}, {7'd0, if_id_flush}, {7'd0, e.fl});
        cmp({tag, ".id_ex_bubble"}, {7'd0, id_ex_bubble}, {7'd0, e.bub});
        cmp({tag, ".ex_mem_hold"}, {7'd0, ex_mem_hold}, {7'd0, e.hold});
        cmp({tag, ".mem_timeout"}, {7'd0, mem_timeout}, {7'd0, e.to});
        cmp({tag, ".state"}, {6'd0, state}, {6'd0, e.st});
        cmp({tag, ".stall_cycles"}, {5'd0, stall_cycles}, {5'd0, e.sc});
        cmp({tag, ".flush_count"}, {5'd0, flush_count}, {5'd0, e.fc});
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset = 1'b1;
        drive(0, 0, 0, 0, 0, 0, 0, 1);
        repeat (2) @(posedge clk);
        #1;
        step("reset", 1, 1, 0, 0, 0, 0, 0, 0, 0);
        reset = 1'b0;
        step("idle", 1, 1, 0, 0, 0, 0, 0, 0, 0);
        drive(5, 1, 1, 5, 1, 0, 0, 1);
        step("lu_stall", 0, 0, 0, 1, 0, 0, 0, 0, 0);
        step("lu_held", 1, 1, 0, 0, 0, 0, 1, 1, 0);
        drive(0, 0, 0, 0, 0, 0, 0, 1);
        step("lu_after", 1, 1, 0, 0, 0, 0, 0, 1, 0);
        drive(5, 1, 0, 5, 1, 1, 0, 1);
        step("br_lu", 1, 1, 1, 1, 0, 0, 0, 1, 0);
        drive(0, 0, 0, 0, 0, 0, 0, 1);
        step("br_after", 1, 1, 0, 0, 0, 0, 0, 1, 1);
        drive(0, 0, 0, 0, 0, 0, 1, 0);
        step("mw1", 0, 0, 0, 0, 1, 0, 0, 1, 1);
        drive(0, 0, 0, 0, 0, 1, 1, 0);
        step("mw2_br", 0, 0, 0, 0, 1, 0, 2, 2, 1);
        drive(0, 0, 0, 0, 0, 0, 1, 0);
        step("mw3", 0, 0, 0, 0, 1, 0, 2, 3, 1);
        drive(0, 0, 0, 0, 0, 0, 1, 1);
        step("mw_release", 1, 1, 0, 0, 0, 0, 2, 4, 1);
        drive(0, 0, 0, 0, 0, 0, 0, 1);
        step("mw_after", 1, 1, 0, 0, 0, 0, 0, 4, 1);
        reset = 1'b1;
        step("reset2", 1, 1, 0, 0, 0, 0, 0, 4, 1);
        reset = 1'b0;
        drive(0, 0, 0, 0, 0, 0, 1, 0);
        for (int k = 1; k <= 6; k++)
            step("wd_freeze", 0, 0, 0, 0, 1, k >= 5, k == 1 ? 2'd0 : 2'd2, 3'(k - 1), 0);
        drive(0, 0, 0, 0, 0, 0, 1, 1);
        step("wd_release", 1, 1, 0, 0, 0, 1, 2, 6, 0);
        drive(0, 0, 0, 0, 0, 0, 0, 1);
        step("wd_sticky", 1, 1, 0, 0, 0, 1, 0, 6, 0);
        drive(0, 0, 0, 0, 0, 0, 1, 0);
        step("sat1", 0, 0, 0, 0, 1, 1, 0, 6, 0);
        step("sat2", 0, 0, 0, 0, 1, 1, 2, 7, 0);
        step("sat3", 0, 0, 0, 0, 1, 1, 2, 7, 0);
        drive(0, 0, 0, 0, 0, 0, 0, 1);
        step("sat_hold", 1, 1, 0, 0, 0, 1, 2, 7, 0);
        reset = 1'b1;
        step("reset3", 1, 1, 0, 0, 0, 1, 0, 7, 0);
        reset = 1'b0;
        step("cleared", 1, 1, 0, 0, 0, 0, 0, 0, 0);
        drive(0, 0, 1, 0, 1, 0, 0, 1);
        step("rd0_nostall", 1, 1, 0, 0, 0, 0, 0, 0, 0);
        drive(1, 7, 0, 7, 1, 0, 0, 1);
        step("rs2_unused", 1, 1, 0, 0, 0, 0, 0, 0, 0);
        drive(1, 7, 1, 7, 1, 0, 0, 1);
        step("rs2_stall", 0, 0, 0, 1, 0, 0, 0, 0, 0);
        drive(0, 0, 0, 0, 0, 0, 0, 1);
        step("rs2_after", 1, 1, 0, 0, 0, 0, 1, 1, 0);
        drive(0, 0, 0, 0, 0, 0, 1, 0);
        step("rmw1", 0, 0, 0, 0, 1, 0, 0, 1, 0);
        step("rmw2", 0, 0, 0, 0, 1, 0, 2, 2, 0);
        reset = 1'b1;
        step("rmw_reset", 1, 1, 0, 0, 0, 0, 2, 3, 0);
        reset = 1'b0;
        drive(0, 0, 0, 0, 0, 0, 0, 1);
        step("rmw_after", 1, 1, 0, 0, 0, 0, 0, 0, 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
